aes_encrypt: RTL and testbench

//   Iterative AES-256 block encryptor (FIPS-197): one 128-bit plaintext block with a 256-bit key in, one 128-bit ciphertext out.

---
 rtl/aes_pkg.sv | 46 ++++
 rtl/aes_sbox.sv | 46 ++++
 rtl/aes_encrypt.sv | 130 +++++++++++++
 tb/tb_aes_encrypt.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES-256 types, constants and the column/row transforms used by the round datapath.
package aes_pkg;

  typedef logic [127:0] aes_block_t;
  typedef logic [255:0] aes_key_t;
  typedef logic [31:0]  aes_word_t;

  localparam logic [3:0] NR = 4'd14;

  // Element i is the Rcon used for round key rk[2*(i+1)].
  localparam logic [7:0][7:0] RCON = {8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Column word holds row 0 in the most significant byte.
  function automatic aes_word_t mix_column(input aes_word_t col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic aes_block_t mix_columns(input aes_block_t s);
    aes_block_t o;
    for (int c = 0; c < 4; c++) begin
      o[127 - 32*c -: 32] = mix_column(s[127 - 32*c -: 32]);
    end
    return o;
  endfunction

  // Byte n sits at column n/4, row n%4; row r rotates left by r columns.
  function automatic aes_block_t shift_rows(input aes_block_t s);
    aes_block_t o;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + r) % 4) + r) -: 8];
      end
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational forward AES S-box, one byte in, one byte out.
module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  always_comb begin
    out_byte = 8'h00;
    case (in_byte)
      8'h00: out_byte = 8'h63; 8'h01: out_byte = 8'h7c; 8'h02: out_byte = 8'h77; 8'h03: out_byte = 8'h7b; 8'h04: out_byte = 8'hf2; 8'h05: out_byte = 8'h6b; 8'h06: out_byte = 8'h6f; 8'h07: out_byte = 8'hc5;
      8'h08: out_byte = 8'h30; 8'h09: out_byte = 8'h01; 8'h0a: out_byte = 8'h67; 8'h0b: out_byte = 8'h2b; 8'h0c: out_byte = 8'hfe; 8'h0d: out_byte = 8'hd7; 8'h0e: out_byte = 8'hab; 8'h0f: out_byte = 8'h76;
      8'h10: out_byte = 8'hca; 8'h11: out_byte = 8'h82; 8'h12: out_byte = 8'hc9; 8'h13: out_byte = 8'h7d; 8'h14: out_byte = 8'hfa; 8'h15: out_byte = 8'h59; 8'h16: out_byte = 8'h47; 8'h17: out_byte = 8'hf0;
      8'h18: out_byte = 8'had; 8'h19: out_byte = 8'hd4; 8'h1a: out_byte = 8'ha2; 8'h1b: out_byte = 8'haf; 8'h1c: out_byte = 8'h9c; 8'h1d: out_byte = 8'ha4; 8'h1e: out_byte = 8'h72; 8'h1f: out_byte = 8'hc0;
      8'h20: out_byte = 8'hb7; 8'h21: out_byte = 8'hfd; 8'h22: out_byte = 8'h93; 8'h23: out_byte = 8'h26; 8'h24: out_byte = 8'h36; 8'h25: out_byte = 8'h3f; 8'h26: out_byte = 8'hf7; 8'h27: out_byte = 8'hcc;
      8'h28: out_byte = 8'h34; 8'h29: out_byte = 8'ha5; 8'h2a: out_byte = 8'he5; 8'h2b: out_byte = 8'hf1; 8'h2c: out_byte = 8'h71; 8'h2d: out_byte = 8'hd8; 8'h2e: out_byte = 8'h31; 8'h2f: out_byte = 8'h15;
      8'h30: out_byte = 8'h04; 8'h31: out_byte = 8'hc7; 8'h32: out_byte = 8'h23; 8'h33: out_byte = 8'hc3; 8'h34: out_byte = 8'h18; 8'h35: out_byte = 8'h96; 8'h36: out_byte = 8'h05; 8'h37: out_byte = 8'h9a;
      8'h38: out_byte = 8'h07; 8'h39: out_byte = 8'h12; 8'h3a: out_byte = 8'h80; 8'h3b: out_byte = 8'he2; 8'h3c: out_byte = 8'heb; 8'h3d: out_byte = 8'h27; 8'h3e: out_byte = 8'hb2; 8'h3f: out_byte = 8'h75;
      8'h40: out_byte = 8'h09; 8'h41: out_byte = 8'h83; 8'h42: out_byte = 8'h2c; 8'h43: out_byte = 8'h1a; 8'h44: out_byte = 8'h1b; 8'h45: out_byte = 8'h6e; 8'h46: out_byte = 8'h5a; 8'h47: out_byte = 8'ha0;
      8'h48: out_byte = 8'h52; 8'h49: out_byte = 8'h3b; 8'h4a: out_byte = 8'hd6; 8'h4b: out_byte = 8'hb3; 8'h4c: out_byte = 8'h29; 8'h4d: out_byte = 8'he3; 8'h4e: out_byte = 8'h2f; 8'h4f: out_byte = 8'h84;
      8'h50: out_byte = 8'h53; 8'h51: out_byte = 8'hd1; 8'h52: out_byte = 8'h00; 8'h53: out_byte = 8'hed; 8'h54: out_byte = 8'h20; 8'h55: out_byte = 8'hfc; 8'h56: out_byte = 8'hb1; 8'h57: out_byte = 8'h5b;
      8'h58: out_byte = 8'h6a; 8'h59: out_byte = 8'hcb; 8'h5a: out_byte = 8'hbe; 8'h5b: out_byte = 8'h39; 8'h5c: out_byte = 8'h4a; 8'h5d: out_byte = 8'h4c; 8'h5e: out_byte = 8'h58; 8'h5f: out_byte = 8'hcf;
      8'h60: out_byte = 8'hd0; 8'h61: out_byte = 8'hef; 8'h62: out_byte = 8'haa; 8'h63: out_byte = 8'hfb; 8'h64: out_byte = 8'h43; 8'h65: out_byte = 8'h4d; 8'h66: out_byte = 8'h33; 8'h67: out_byte = 8'h85;
      8'h68: out_byte = 8'h45; 8'h69: out_byte = 8'hf9; 8'h6a: out_byte = 8'h02; 8'h6b: out_byte = 8'h7f; 8'h6c: out_byte = 8'h50; 8'h6d: out_byte = 8'h3c; 8'h6e: out_byte = 8'h9f; 8'h6f: out_byte = 8'ha8;
      8'h70: out_byte = 8'h51; 8'h71: out_byte = 8'ha3; 8'h72: out_byte = 8'h40; 8'h73: out_byte = 8'h8f; 8'h74: out_byte = 8'h92; 8'h75: out_byte = 8'h9d; 8'h76: out_byte = 8'h38; 8'h77: out_byte = 8'hf5;
      8'h78: out_byte = 8'hbc; 8'h79: out_byte = 8'hb6; 8'h7a: out_byte = 8'hda; 8'h7b: out_byte = 8'h21; 8'h7c: out_byte = 8'h10; 8'h7d: out_byte = 8'hff; 8'h7e: out_byte = 8'hf3; 8'h7f: out_byte = 8'hd2;
      8'h80: out_byte = 8'hcd; 8'h81: out_byte = 8'h0c; 8'h82: out_byte = 8'h13; 8'h83: out_byte = 8'hec; 8'h84: out_byte = 8'h5f; 8'h85: out_byte = 8'h97; 8'h86: out_byte = 8'h44; 8'h87: out_byte = 8'h17;
      8'h88: out_byte = 8'hc4; 8'h89: out_byte = 8'ha7; 8'h8a: out_byte = 8'h7e; 8'h8b: out_byte = 8'h3d; 8'h8c: out_byte = 8'h64; 8'h8d: out_byte = 8'h5d; 8'h8e: out_byte = 8'h19; 8'h8f: out_byte = 8'h73;
      8'h90: out_byte = 8'h60; 8'h91: out_byte = 8'h81; 8'h92: out_byte = 8'h4f; 8'h93: out_byte = 8'hdc; 8'h94: out_byte = 8'h22; 8'h95: out_byte = 8'h2a; 8'h96: out_byte = 8'h90; 8'h97: out_byte = 8'h88;
      8'h98: out_byte = 8'h46; 8'h99: out_byte = 8'hee; 8'h9a: out_byte = 8'hb8; 8'h9b: out_byte = 8'h14; 8'h9c: out_byte = 8'hde; 8'h9d: out_byte = 8'h5e; 8'h9e: out_byte = 8'h0b; 8'h9f: out_byte = 8'hdb;
      8'ha0: out_byte = 8'he0; 8'ha1: out_byte = 8'h32; 8'ha2: out_byte = 8'h3a; 8'ha3: out_byte = 8'h0a; 8'ha4: out_byte = 8'h49; 8'ha5: out_byte = 8'h06; 8'ha6: out_byte = 8'h24; 8'ha7: out_byte = 8'h5c;
      8'ha8: out_byte = 8'hc2; 8'ha9: out_byte = 8'hd3; 8'haa: out_byte = 8'hac; 8'hab: out_byte = 8'h62; 8'hac: out_byte = 8'h91; 8'had: out_byte = 8'h95; 8'hae: out_byte = 8'he4; 8'haf: out_byte = 8'h79;
      8'hb0: out_byte = 8'he7; 8'hb1: out_byte = 8'hc8; 8'hb2: out_byte = 8'h37; 8'hb3: out_byte = 8'h6d; 8'hb4: out_byte = 8'h8d; 8'hb5: out_byte = 8'hd5; 8'hb6: out_byte = 8'h4e; 8'hb7: out_byte = 8'ha9;
      8'hb8: out_byte = 8'h6c; 8'hb9: out_byte = 8'h56; 8'hba: out_byte = 8'hf4; 8'hbb: out_byte = 8'hea; 8'hbc: out_byte = 8'h65; 8'hbd: out_byte = 8'h7a; 8'hbe: out_byte = 8'hae; 8'hbf: out_byte = 8'h08;
      8'hc0: out_byte = 8'hba; 8'hc1: out_byte = 8'h78; 8'hc2: out_byte = 8'h25; 8'hc3: out_byte = 8'h2e; 8'hc4: out_byte = 8'h1c; 8'hc5: out_byte = 8'ha6; 8'hc6: out_byte = 8'hb4; 8'hc7: out_byte = 8'hc6;
      8'hc8: out_byte = 8'he8; 8'hc9: out_byte = 8'hdd; 8'hca: out_byte = 8'h74; 8'hcb: out_byte = 8'h1f; 8'hcc: out_byte = 8'h4b; 8'hcd: out_byte = 8'hbd; 8'hce: out_byte = 8'h8b; 8'hcf: out_byte = 8'h8a;
      8'hd0: out_byte = 8'h70; 8'hd1: out_byte = 8'h3e; 8'hd2: out_byte = 8'hb5; 8'hd3: out_byte = 8'h66; 8'hd4: out_byte = 8'h48; 8'hd5: out_byte = 8'h03; 8'hd6: out_byte = 8'hf6; 8'hd7: out_byte = 8'h0e;
      8'hd8: out_byte = 8'h61; 8'hd9: out_byte = 8'h35; 8'hda: out_byte = 8'h57; 8'hdb: out_byte = 8'hb9; 8'hdc: out_byte = 8'h86; 8'hdd: out_byte = 8'hc1; 8'hde: out_byte = 8'h1d; 8'hdf: out_byte = 8'h9e;
      8'he0: out_byte = 8'he1; 8'he1: out_byte = 8'hf8; 8'he2: out_byte = 8'h98; 8'he3: out_byte = 8'h11; 8'he4: out_byte = 8'h69; 8'he5: out_byte = 8'hd9; 8'he6: out_byte = 8'h8e; 8'he7: out_byte = 8'h94;
      8'he8: out_byte = 8'h9b; 8'he9: out_byte = 8'h1e; 8'hea: out_byte = 8'h87; 8'heb: out_byte = 8'he9; 8'hec: out_byte = 8'hce; 8'hed: out_byte = 8'h55; 8'hee: out_byte = 8'h28; 8'hef: out_byte = 8'hdf;
      8'hf0: out_byte = 8'h8c; 8'hf1: out_byte = 8'ha1; 8'hf2: out_byte = 8'h89; 8'hf3: out_byte = 8'h0d; 8'hf4: out_byte = 8'hbf; 8'hf5: out_byte = 8'he6; 8'hf6: out_byte = 8'h42; 8'hf7: out_byte = 8'h68;
      8'hf8: out_byte = 8'h41; 8'hf9: out_byte = 8'h99; 8'hfa: out_byte = 8'h2d; 8'hfb: out_byte = 8'h0f; 8'hfc: out_byte = 8'hb0; 8'hfd: out_byte = 8'h54; 8'hfe: out_byte = 8'hbb; 8'hff: out_byte = 8'h16;
      default: out_byte = 8'h00;
    endcase
  end

endmodule

// File: rtl/aes_encrypt.sv
// Iterative AES-256 encryptor: one round per clock, round keys expanded on the fly
// through a two-entry window {A, B} = {rk[r], rk[r+1]}.
module aes_encrypt
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] plaintext,
  input  logic [255:0] key,
  output logic [127:0] ciphertext,
  output logic         busy,
  output logic         done
);

  aes_block_t state_q, state_d;
  aes_block_t win_a_q, win_a_d;
  aes_block_t win_b_q, win_b_d;
  aes_block_t ct_q, ct_d;
  logic [3:0] round_q, round_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic       start_ok;
  aes_block_t sb_state, sr_state, mc_state;

  aes_block_t exp_p;
  aes_word_t  exp_q3, sw_in, sw_out, exp_t;
  aes_word_t  w0, w1, w2, w3;
  logic       exp_even;
  logic [7:0] exp_rcon;
  aes_block_t rk_next;

  assign start_ok = start & ~busy_q;

  for (genvar i = 0; i < 16; i++) begin : g_sub_bytes
    aes_sbox u_sbox (
      .in_byte  (state_q[8*i +: 8]),
      .out_byte (sb_state[8*i +: 8])
    );
  end

  assign sr_state = shift_rows(sb_state);
  assign mc_state = mix_columns(sr_state);

  // The same expansion hardware produces rk2 from the raw key at start and rk[r+2] during rounds.
  always_comb begin
    if (start_ok) begin
      exp_p    = key[255:128];
      exp_q3   = key[31:0];
      exp_even = 1'b1;
      exp_rcon = RCON[0];
    end else begin
      exp_p    = win_a_q;
      exp_q3   = win_b_q[31:0];
      exp_even = ~round_q[0];
      exp_rcon = RCON[round_q[3:1]];
    end
  end

  assign sw_in = exp_even ? {exp_q3[23:0], exp_q3[31:24]} : exp_q3;

  for (genvar j = 0; j < 4; j++) begin : g_sub_word
    aes_sbox u_sbox (
      .in_byte  (sw_in[8*j +: 8]),
      .out_byte (sw_out[8*j +: 8])
    );
  end

  assign exp_t   = sw_out ^ (exp_even ? {exp_rcon, 24'h000000} : 32'h00000000);
  assign w0      = exp_p[127:96] ^ exp_t;
  assign w1      = exp_p[95:64]  ^ w0;
  assign w2      = exp_p[63:32]  ^ w1;
  assign w3      = exp_p[31:0]   ^ w2;
  assign rk_next = {w0, w1, w2, w3};

  always_comb begin
    state_d = state_q;
    win_a_d = win_a_q;
    win_b_d = win_b_q;
    ct_d    = ct_q;
    round_d = round_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (start_ok) begin
      state_d = plaintext ^ key[255:128];
      win_a_d = key[127:0];
      win_b_d = rk_next;
      round_d = 4'd1;
      busy_d  = 1'b1;
    end else if (busy_q) begin
      if (round_q == NR) begin
        ct_d    = sr_state ^ win_a_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        round_d = 4'd0;
      end else begin
        state_d = mc_state ^ win_a_q;
        win_a_d = win_b_q;
        win_b_d = rk_next;
        round_d = round_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= '0;
      win_a_q <= '0;
      win_b_q <= '0;
      ct_q    <= '0;
      round_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      win_a_q <= win_a_d;
      win_b_q <= win_b_d;
      ct_q    <= ct_d;
      round_q <= round_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign ciphertext = ct_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_aes_encrypt.sv
// Self-checking bench for aes_encrypt: known-answer vectors, latency, ignored restart,
// mid-run reset and back-to-back operation, with a ciphertext scoreboard.
module tb_aes_encrypt;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [127:0] plaintext;
  logic [255:0] key;
  logic [127:0] ciphertext;
  logic         busy;
  logic         done;

  typedef struct {
    logic [127:0] pt;
    logic [255:0] key;
    logic [127:0] ct;
  } vec_t;

  vec_t         vecs [2];
  logic [127:0] sb_q [$];
  logic [127:0] model_ct;
  int           errors;
  int           checks;
  int           cyc;

  aes_encrypt dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .plaintext  (plaintext),
    .key        (key),
    .ciphertext (ciphertext),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got ct %h expected no done pulse", ciphertext);
      end else begin
        logic [127:0] exp_ct;
        exp_ct = sb_q.pop_front();
        if (ciphertext !== exp_ct) begin
          errors++;
          $display("FAIL ciphertext: got %h expected %h", ciphertext, exp_ct);
        end
      end
    end
  end

  // One block with full latency checks; optionally re-pulse start with the other vector mid-run.
  task automatic run_block(input int idx, input int inject_at);
    @(negedge clk);
    plaintext = vecs[idx].pt;
    key       = vecs[idx].key;
    start     = 1'b1;
    sb_q.push_back(vecs[idx].ct);
    @(negedge clk);
    start     = 1'b0;
    plaintext = '1;
    key       = '1;
    for (int c = 0; c < 14; c++) begin
      if (c == inject_at) begin
        start     = 1'b1;
        plaintext = vecs[1-idx].pt;
        key       = vecs[1-idx].key;
      end
      if (c == inject_at + 2) start = 1'b0;
      check("busy_running", busy, 1);
      check("done_early", done, 0);
      check("ct_hold_busy", ciphertext, model_ct);
      @(negedge clk);
    end
    check("done_pulse", done, 1);
    check("busy_cleared", busy, 0);
    model_ct = vecs[idx].ct;
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("ct_held_after", ciphertext, model_ct);
  endtask

  initial begin
    int first_done;
    int n;

    vecs[0].pt  = 128'h00112233445566778899aabbccddeeff;
    vecs[0].key = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    vecs[0].ct  = 128'h8ea2b7ca516745bfeafc49904b496089;
    vecs[1].pt  = '0;
    vecs[1].key = '0;
    vecs[1].ct  = 128'hdc95c078a2408989ad48a21492842087;

    errors    = 0;
    checks    = 0;
    cyc       = 0;
    model_ct  = '0;
    rst_n     = 1'b0;
    start     = 1'b0;
    plaintext = '0;
    key       = '0;

    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_ct", ciphertext, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 2; i++) run_block(i, -1);

    // Restart attempt mid-run must not disturb the running block.
    run_block(0, 5);
    repeat (20) @(negedge clk);

    // Asynchronous reset around round 7 aborts the block.
    @(negedge clk);
    plaintext = vecs[1].pt;
    key       = vecs[1].key;
    start     = 1'b1;
    sb_q.push_back(vecs[1].ct);
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_ct", ciphertext, 0);
    sb_q.delete();
    model_ct = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("no_done_after_abort", done, 0);
    end
    run_block(0, -1);

    // Start held high across two blocks.
    @(negedge clk);
    plaintext = vecs[0].pt;
    key       = vecs[0].key;
    start     = 1'b1;
    sb_q.push_back(vecs[0].ct);
    n = 0;
    while (!done && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("b2b_first_done", done, 1);
    first_done = cyc;
    plaintext  = vecs[1].pt;
    key        = vecs[1].key;
    sb_q.push_back(vecs[1].ct);
    @(negedge clk);
    start = 1'b0;
    check("b2b_restart_busy", busy, 1);
    n = 0;
    while (!done && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("b2b_second_done", done, 1);
    check("b2b_spacing", cyc - first_done, 15);
    model_ct = vecs[1].ct;
    @(negedge clk);
    check("b2b_final_ct", ciphertext, model_ct);

    repeat (20) @(negedge clk);
    check("scoreboard_empty", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
